fifo_rd_stream: RTL and testbench

Read-domain consumer for the async FIFO. It sits between the read-pointer/empty logic and the FIFO memory on one side, and a downstream valid/ready stream on the other. It issues rinc pops, captures memory read data into a 3-entry skid queue, and presents words on m_valid/m_ready at one word per cycle. It also reports FIFO occupancy and almost-empty status, computed from the synchronized Gray write pointer.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/rd_skid_queue.sv | 51 +++++
 rtl/fifo_rd_stream.sv | 67 ++++++
 tb/tb_fifo_rd_stream.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO read/write domains.
// Pointers are ADDRSIZE+1 bits wide; Gray-to-binary conversion lives here.
package fifo_pkg;

   localparam int DATASIZE   = 8;
   localparam int ADDRSIZE   = 9;
   localparam int SKID_DEPTH = 3;

   typedef logic [ADDRSIZE:0] ptr_t;

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[ADDRSIZE] = g[ADDRSIZE];
      for (int i = ADDRSIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rd_skid_queue.sv
// Three-entry shift-style skid queue; entry 0 is always the head word.
// Simultaneous push and pop keeps the count and shifts the new word in behind the survivors.
module rd_skid_queue #(
   parameter int DATASIZE = fifo_pkg::DATASIZE
) (
   input  logic                rclk,
   input  logic                r_rst,
   input  logic                push,
   input  logic [DATASIZE-1:0] push_data,
   input  logic                pop,
   output logic [1:0]          qcount,
   output logic                head_valid,
   output logic [DATASIZE-1:0] head_data
);
   import fifo_pkg::*;

   logic [DATASIZE-1:0] entries [SKID_DEPTH];
   logic                pop_ok;
   logic                push_ok;
   logic [1:0]          wr_idx;

   assign head_valid = (qcount != 2'd0);
   assign head_data  = entries[0];
   assign pop_ok     = pop & head_valid;
   assign push_ok    = push & ((qcount != 2'(SKID_DEPTH)) | pop_ok);
   assign wr_idx     = pop_ok ? qcount - 2'd1 : qcount;

   // NOTE: the storage is only three words and the head drives m_data directly,
   // so it is reset to give m_data a defined zero out of reset.
   always_ff @(posedge rclk or posedge r_rst) begin
      if (r_rst) begin
         qcount <= 2'd0;
         for (int i = 0; i < SKID_DEPTH; i++) entries[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let the shift and the tail write
         // coexist; the later write to the same entry wins.
         if (pop_ok) begin
            for (int i = 0; i < SKID_DEPTH - 1; i++) entries[i] <= entries[i+1];
         end
         for (int i = 0; i < SKID_DEPTH; i++) begin
            if (push_ok && (wr_idx == 2'(i))) entries[i] <= push_data;
         end
         case ({push_ok, pop_ok})
            2'b10:   qcount <= qcount + 2'd1;
            2'b01:   qcount <= qcount - 2'd1;
            default: qcount <= qcount;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: issues pops with a fixed one-cycle memory latency,
// buffers words in a skid queue and streams them out; also reports occupancy.
module fifo_rd_stream #(
   parameter int DATASIZE      = fifo_pkg::DATASIZE,
   parameter int ADDRSIZE      = fifo_pkg::ADDRSIZE,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                rclk,
   input  logic                r_rst,
   input  logic                rd_en,
   input  logic                rempty,
   input  logic [ADDRSIZE:0]   raddr,
   input  logic [ADDRSIZE:0]   wptr_sync,
   input  logic [DATASIZE-1:0] rdata,
   output logic                rinc,
   output logic                m_valid,
   output logic [DATASIZE-1:0] m_data,
   input  logic                m_ready,
   output logic [ADDRSIZE:0]   rlevel,
   output logic                almost_empty,
   output logic [31:0]         rd_count
);
   import fifo_pkg::*;

   localparam logic [ADDRSIZE:0] AE_THRESH = (ADDRSIZE + 1)'(AEMPTY_THRESH);

   logic              inflight;
   logic [1:0]        qcount;
   logic [2:0]        outstanding;
   logic              deliver;
   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] lvl_next;

   rd_skid_queue #(.DATASIZE(DATASIZE)) u_queue (
      .rclk       (rclk),
      .r_rst      (r_rst),
      .push       (inflight),
      .push_data  (rdata),
      .pop        (deliver),
      .qcount     (qcount),
      .head_valid (m_valid),
      .head_data  (m_data)
   );

   // Room is judged on queued plus outstanding words, so a landing word always fits.
   assign outstanding = {1'b0, qcount} + {2'b00, inflight};
   assign rinc        = rd_en & ~rempty & ~r_rst & (outstanding <= 3'd2);
   assign deliver     = m_valid & m_ready;

   assign wbin     = gray2bin(wptr_sync);
   assign lvl_next = wbin - raddr;

   always_ff @(posedge rclk or posedge r_rst) begin
      if (r_rst) begin
         inflight     <= 1'b0;
         rlevel       <= '0;
         almost_empty <= 1'b1;
         rd_count     <= 32'd0;
      end else begin
         inflight     <= rinc;
         rlevel       <= lvl_next;
         almost_empty <= (lvl_next <= AE_THRESH);
         if (deliver) rd_count <= rd_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomized bench for fifo_rd_stream, checked against a
// word-level model of the FIFO memory, skid buffering and occupancy arithmetic.
module tb_fifo_rd_stream;

   localparam int DW = 8;
   localparam int AW = 9;

   logic          rclk = 1'b0;
   logic          r_rst = 1'b0;
   logic          rd_en;
   logic          rempty;
   logic [AW:0]   raddr;
   logic [AW:0]   wptr_sync;
   logic [DW-1:0] rdata;
   logic          rinc;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [AW:0]   rlevel;
   logic          almost_empty;
   logic [31:0]   rd_count;

   fifo_rd_stream #(.DATASIZE(DW), .ADDRSIZE(AW), .AEMPTY_THRESH(4)) dut (
      .rclk         (rclk),
      .r_rst        (r_rst),
      .rd_en        (rd_en),
      .rempty       (rempty),
      .raddr        (raddr),
      .wptr_sync    (wptr_sync),
      .rdata        (rdata),
      .rinc         (rinc),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_ready      (m_ready),
      .rlevel       (rlevel),
      .almost_empty (almost_empty),
      .rd_count     (rd_count)
   );

   always #5 rclk = ~rclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [DW-1:0] landed [$];
   logic [DW-1:0] src_q  [$];
   bit            pend;
   logic [DW-1:0] pend_word;
   logic [31:0]   exp_count;
   logic [AW:0]   exp_lvl;
   bit            exp_ae;
   int            dut_rinc_cnt;

   function automatic logic [AW:0] g2b(input logic [AW:0] g);
      logic [AW:0] b = '0;
      for (int i = 0; i <= AW; i++) b = b ^ (g >> i);
      return b;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      landed.delete();
      pend      = 1'b0;
      pend_word = '0;
      exp_count = 32'd0;
      exp_lvl   = '0;
      exp_ae    = 1'b1;
   endtask

   // Entered at a negedge with inputs set; returns at the following negedge.
   task automatic step();
      bit          exp_rinc;
      logic [AW:0] lvl;
      #1;
      exp_rinc = rd_en && !rempty && ((landed.size() + int'(pend)) <= 2);
      check("rinc", 32'(rinc), 32'(exp_rinc));
      check("m_valid", 32'(m_valid), 32'(landed.size() != 0));
      if (landed.size() != 0) check("m_data", 32'(m_data), 32'(landed[0]));
      check("rd_count", rd_count, exp_count);
      check("rlevel", 32'(rlevel), 32'(exp_lvl));
      check("almost_empty", 32'(almost_empty), 32'(exp_ae));
      if (rinc === 1'b1) dut_rinc_cnt++;
      @(posedge rclk);
      if ((landed.size() != 0) && m_ready) begin
         void'(landed.pop_front());
         exp_count++;
      end
      if (pend) begin
         check("skid_room", 32'(landed.size() <= 2), 32'd1);
         landed.push_back(pend_word);
      end
      pend = exp_rinc;
      if (exp_rinc) begin
         if (src_q.size() != 0) pend_word = src_q.pop_front();
         else                   pend_word = 8'($urandom);
      end
      lvl     = g2b(wptr_sync) - raddr;
      exp_lvl = lvl;
      exp_ae  = (lvl <= 10'd4);
      #1;
      rdata = pend ? pend_word : 8'($urandom);
      @(negedge rclk);
   endtask

   task automatic reset_now();
      r_rst = 1'b1;
      #1;
      check("rst_rinc", 32'(rinc), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_rlevel", 32'(rlevel), 32'd0);
      check("rst_almost_empty", 32'(almost_empty), 32'd1);
      check("rst_rd_count", rd_count, 32'd0);
      model_reset();
      r_rst = 1'b0;
   endtask

   initial begin
      logic [31:0] base_cnt;
      int          base_rinc;

      rd_en = 1'b1; rempty = 1'b1; m_ready = 1'b1;
      raddr = '0; wptr_sync = '0; rdata = '0;
      dut_rinc_cnt = 0;
      model_reset();
      #1 r_rst = 1'b1;
      @(negedge rclk);
      reset_now();

      // Empty FIFO after reset: no pops
      repeat (3) step();

      // Single word
      src_q.push_back(8'hA5);
      base_cnt = rd_count; base_rinc = dut_rinc_cnt;
      rempty = 1'b0; step();
      rempty = 1'b1; repeat (4) step();
      check("single_pops", 32'(dut_rinc_cnt - base_rinc), 32'd1);
      check("single_count", rd_count, base_cnt + 32'd1);

      // Streaming 16 words
      for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
      base_cnt = rd_count; base_rinc = dut_rinc_cnt;
      rempty = 1'b0; repeat (16) step();
      rempty = 1'b1; repeat (5) step();
      check("stream_pops", 32'(dut_rinc_cnt - base_rinc), 32'd16);
      check("stream_count", rd_count, base_cnt + 32'd16);

      // Backpressure
      for (int i = 0; i < 3; i++) src_q.push_back(8'(i));
      base_cnt = rd_count; base_rinc = dut_rinc_cnt;
      m_ready = 1'b0; rempty = 1'b0; repeat (10) step();
      check("bp_pops", 32'(dut_rinc_cnt - base_rinc), 32'd3);
      check("bp_head", 32'(m_data), 32'd0);
      m_ready = 1'b1; rempty = 1'b1; repeat (6) step();
      check("bp_count", rd_count, base_cnt + 32'd3);

      // Occupancy and pointer wrap
      raddr = 10'd1020; wptr_sync = 10'h006; step();
      check("occ_lvl8", 32'(rlevel), 32'd8);
      check("occ_ae8", 32'(almost_empty), 32'd0);
      raddr = 10'd1022; step();
      check("occ_lvl6", 32'(rlevel), 32'd6);
      raddr = 10'd1021; wptr_sync = 10'h000; step();
      check("occ_lvl3", 32'(rlevel), 32'd3);
      check("occ_ae3", 32'(almost_empty), 32'd1);
      raddr = '0; wptr_sync = '0;

      // rd_en dropped right after a pop
      src_q.push_back(8'h3C);
      base_cnt = rd_count; base_rinc = dut_rinc_cnt;
      rempty = 1'b0; step();
      rd_en = 1'b0; repeat (5) step();
      check("rden_pops", 32'(dut_rinc_cnt - base_rinc), 32'd1);
      check("rden_count", rd_count, base_cnt + 32'd1);
      rd_en = 1'b1;

      // Alternating empty flag
      base_cnt = rd_count; base_rinc = dut_rinc_cnt;
      for (int i = 0; i < 20; i++) begin
         rempty = (i % 2) == 1;
         step();
      end
      rempty = 1'b1; repeat (5) step();
      check("alt_balance", rd_count - base_cnt, 32'(dut_rinc_cnt - base_rinc));

      // Randomized traffic with a reset in the middle of it
      for (int i = 0; i < 400; i++) begin
         rd_en     = ($urandom % 4) != 0;
         rempty    = ($urandom % 3) == 0;
         m_ready   = ($urandom % 2) == 0;
         raddr     = 10'($urandom);
         wptr_sync = 10'($urandom);
         if (i == 200) begin
            rempty = 1'b0;
            reset_now();
         end
         step();
      end

      // Drain and confirm nothing was lost
      rempty = 1'b1; m_ready = 1'b1;
      repeat (6) step();
      check("final_drained", 32'(m_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
